// File: rtl/pixel_feeder_pkg.sv
// Shared timing constants, RGB565 colours and state encodings for the pixel feeder.
package pixel_feeder_pkg;

  localparam int H_TOTAL   = 1056;
  localparam int V_TOTAL   = 628;
  localparam int H_VISIBLE = 800;
  localparam int V_VISIBLE = 600;
  localparam int POS_W     = 11;

  localparam logic [15:0] RGB565_BLACK   = 16'h0000;
  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_FAULT
  } feed_state_t;

  // Registered choice of what drives pixel_out one cycle after stage 0.
  typedef enum logic [1:0] {
    PIX_BLACK,
    PIX_FIFO,
    PIX_FILL
  } pix_sel_t;

endpackage

// File: rtl/vga_position_counter.sv
// Stage-0 raster position generator: cx runs across a line, cy steps once per line.
module vga_position_counter
  import pixel_feeder_pkg::*;
#(
  parameter int H_PERIOD = 1056,
  parameter int V_PERIOD = 628
) (
  input  logic             clk25,
  input  logic             rst,
  output logic [POS_W-1:0] cx,
  output logic [POS_W-1:0] cy,
  output logic             frame_end
);

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_PERIOD - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_PERIOD - 1);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == H_LAST) begin
      cx <= '0;
      cy <= (cy == V_LAST) ? '0 : cy + POS_W'(1);
    end else begin
      cx <= cx + POS_W'(1);
    end
  end

  assign frame_end = (cx == H_LAST) && (cy == V_LAST);

endmodule

// File: rtl/pixel_feeder.sv
// Pulls RGB565 words from the line FIFO in step with the raster and fills
// starved frames with a marker colour until upstream has resynchronised.
module pixel_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int          H_TOTAL          = pixel_feeder_pkg::H_TOTAL,
  parameter int          V_TOTAL          = pixel_feeder_pkg::V_TOTAL,
  parameter int          H_VISIBLE        = pixel_feeder_pkg::H_VISIBLE,
  parameter int          V_VISIBLE        = pixel_feeder_pkg::V_VISIBLE,
  parameter logic [15:0] UNDERFLOW_COLOUR = RGB565_MAGENTA,
  parameter int          COUNT_W          = 16
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic [15:0]        fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  output logic [15:0]        pixel_out,
  output logic [POS_W-1:0]   pixel_x,
  output logic [POS_W-1:0]   pixel_y,
  output logic               line_request,
  output logic               resync_req,
  output logic [COUNT_W-1:0] underflow_count
);

  localparam logic [POS_W-1:0] H_VIS      = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] V_VIS      = POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] H_VIS_LAST = POS_W'(H_VISIBLE - 1);
  localparam logic [POS_W-1:0] V_VIS_LAST = POS_W'(V_VISIBLE - 1);
  localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);

  logic [POS_W-1:0] cx, cy;
  logic             frame_end;
  logic             visible, last_visible, underflow;
  feed_state_t      state, next_state;
  logic             fault_hold, next_fault_hold;
  pix_sel_t         pix_sel, sel;

  vga_position_counter #(
    .H_PERIOD(H_TOTAL),
    .V_PERIOD(V_TOTAL)
  ) u_position (
    .clk25    (clk25),
    .rst      (rst),
    .cx       (cx),
    .cy       (cy),
    .frame_end(frame_end)
  );

  assign visible      = (cx < H_VIS) && (cy < V_VIS);
  assign last_visible = (cx == H_VIS_LAST) && (cy == V_VIS_LAST);
  assign underflow    = (state == ST_RUN) && visible && fifo_empty;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state      <= ST_WAIT;
      fault_hold <= 1'b0;
    end else begin
      state      <= next_state;
      fault_hold <= next_fault_hold;
    end
  end

  // Starving on the final visible pixel leaves nothing of that frame to blank,
  // so fault_hold makes FAULT skip one frame wrap and cover the whole next frame.
  always_comb begin
    next_state      = state;
    next_fault_hold = fault_hold;
    unique case (state)
      ST_WAIT:  if (frame_end && !fifo_empty) next_state = ST_RUN;
      ST_RUN: begin
        if (underflow) begin
          next_state      = ST_FAULT;
          next_fault_hold = last_visible;
        end
      end
      ST_FAULT: begin
        if (frame_end) begin
          if (fault_hold) next_fault_hold = 1'b0;
          else            next_state      = ST_WAIT;
        end
      end
      default:  next_state = ST_WAIT;
    endcase
  end

  always_comb begin
    fifo_rd_en   = 1'b0;
    resync_req   = 1'b0;
    pix_sel      = PIX_BLACK;
    line_request = (state != ST_FAULT) && (cx == H_VIS) &&
                   ((cy < V_VIS_LAST) || (cy == V_LAST));
    unique case (state)
      ST_RUN: begin
        fifo_rd_en = visible && !fifo_empty;
        resync_req = underflow;
        if (visible) pix_sel = fifo_empty ? PIX_FILL : PIX_FIFO;
      end
      ST_FAULT: if (visible) pix_sel = PIX_FILL;
      default:  pix_sel = PIX_BLACK;
    endcase
  end

  // The FIFO word arrives one cycle after the pop, so only the source select
  // is registered and pixel_out muxes the live fifo_data against it.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      pixel_x         <= '0;
      pixel_y         <= '0;
      sel             <= PIX_BLACK;
      underflow_count <= '0;
    end else begin
      pixel_x <= cx;
      pixel_y <= cy;
      sel     <= pix_sel;
      if (underflow && (underflow_count != '1))
        underflow_count <= underflow_count + COUNT_W'(1);
    end
  end

  assign pixel_out = (sel == PIX_FIFO) ? fifo_data :
                     (sel == PIX_FILL) ? UNDERFLOW_COLOUR : RGB565_BLACK;

endmodule

// File: tb/tb_pixel_feeder.sv
// Self-checking bench for pixel_feeder on a shrunken raster so several whole
// frames fit; a cycle-based reference model predicts every output.
module tb_pixel_feeder;

  localparam int          HT      = 16;
  localparam int          VT      = 10;
  localparam int          HV      = 10;
  localparam int          VV      = 6;
  localparam int          CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam int          FRAME   = HT * VT;
  localparam logic [15:0] FILL    = 16'hF81F;
  localparam int          M_WAIT  = 0;
  localparam int          M_RUN   = 1;
  localparam int          M_FAULT = 2;

  logic          clk25 = 1'b0;
  logic          rst;
  logic [15:0]   fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [15:0]   pixel_out;
  logic [10:0]   pixel_x;
  logic [10:0]   pixel_y;
  logic          line_request;
  logic          resync_req;
  logic [CW-1:0] underflow_count;

  pixel_feeder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .UNDERFLOW_COLOUR(FILL), .COUNT_W(CW)
  ) dut (
    .clk25(clk25), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .pixel_out(pixel_out), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .line_request(line_request), .resync_req(resync_req),
    .underflow_count(underflow_count)
  );

  always #5 clk25 = ~clk25;

  int checks = 0;
  int failures = 0;

  // Reference model: position comes from the cycle count since reset release.
  int          t;
  int          mMode;
  bit          mHold;
  int          mCount;
  logic [15:0] expPix;
  int          expPx, expPy;
  bit          starve;
  bit          rampMode;
  logic [15:0] nextWord;
  int          pops, linePulses, resyncPulses;
  bit          capAOn, capBOn;
  int          capAX, capAY, capBX, capBY;
  logic [15:0] capAVal, capBVal;

  function automatic int posX(input int tt);
    return tt % HT;
  endfunction

  function automatic int posY(input int tt);
    return (tt / HT) % VT;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic resetModel();
    t = 0; mMode = M_WAIT; mHold = 1'b0; mCount = 0;
    expPix = 16'h0000; expPx = 0; expPy = 0;
  endtask

  task automatic applyStimulus(input bit s);
    starve     = s;
    fifo_empty = s;
  endtask

  task automatic checkOutput();
    int x, y;
    bit vis;
    x   = posX(t);
    y   = posY(t);
    vis = (x < HV) && (y < VV);
    checkEq("fifo_rd_en", 32'(fifo_rd_en), 32'(mMode == M_RUN && vis && !starve));
    checkEq("resync_req", 32'(resync_req), 32'(mMode == M_RUN && vis && starve));
    checkEq("line_request", 32'(line_request),
            32'(mMode != M_FAULT && x == HV && (y < VV - 1 || y == VT - 1)));
    checkEq("pixel_out", 32'(pixel_out), 32'(expPix));
    checkEq("pixel_x", 32'(pixel_x), 32'(expPx));
    checkEq("pixel_y", 32'(pixel_y), 32'(expPy));
    checkEq("underflow_count", 32'(underflow_count), 32'(mCount));
    if (fifo_rd_en)   pops++;
    if (line_request) linePulses++;
    if (resync_req)   resyncPulses++;
    if (capAOn && expPx == capAX && expPy == capAY) begin capAVal = pixel_out; capAOn = 0; end
    if (capBOn && expPx == capBX && expPy == capBY) begin capBVal = pixel_out; capBOn = 0; end
  endtask

  task automatic advance();
    int x, y;
    bit vis, pop, uf, last;
    x    = posX(t);
    y    = posY(t);
    vis  = (x < HV) && (y < VV);
    pop  = (mMode == M_RUN) && vis && !starve;
    uf   = (mMode == M_RUN) && vis && starve;
    last = (x == HT - 1) && (y == VT - 1);
    @(posedge clk25);
    #1;
    if (pop) begin
      fifo_data = nextWord;
      expPix    = nextWord;
      nextWord  = rampMode ? nextWord + 16'd1 : 16'($urandom);
    end else begin
      fifo_data = 16'($urandom);
      expPix    = (vis && mMode != M_WAIT) ? FILL : 16'h0000;
    end
    expPx = x;
    expPy = y;
    if (uf && mCount < CNT_MAX) mCount++;
    if (mMode == M_WAIT && last && !starve) mMode = M_RUN;
    else if (uf) begin
      mMode = M_FAULT;
      mHold = (x == HV - 1) && (y == VV - 1);
    end else if (mMode == M_FAULT && last) begin
      if (mHold) mHold = 1'b0;
      else       mMode = M_WAIT;
    end
    t++;
  endtask

  task automatic tick(input bit s);
    applyStimulus(s);
    @(negedge clk25);
    checkOutput();
    advance();
  endtask

  task automatic waitMode(input int target, input bit s, input string tag);
    int n = 0;
    while (mMode != target && n < 4 * FRAME) begin
      tick(s);
      n++;
    end
    checkEq(tag, 32'(n < 4 * FRAME), 32'd1);
  endtask

  task automatic tickUntil(input int x, input int y, input bit s, input string tag);
    int n = 0;
    while (!(posX(t) == x && posY(t) == y) && n < 2 * FRAME) begin
      tick(s);
      n++;
    end
    checkEq(tag, 32'(n < 2 * FRAME), 32'd1);
  endtask

  initial begin
    rst = 1'b1; fifo_empty = 1'b0; fifo_data = 16'h1234;
    starve = 1'b0; rampMode = 1'b0; nextWord = 16'($urandom);
    capAOn = 0; capBOn = 0; capAX = 0; capAY = 0; capBX = 0; capBY = 0;
    capAVal = 16'hxxxx; capBVal = 16'hxxxx;
    pops = 0; linePulses = 0; resyncPulses = 0;
    resetModel();

    repeat (3) @(posedge clk25);
    #1;
    checkEq("reset pixel_x", 32'(pixel_x), 32'd0);
    checkEq("reset pixel_y", 32'(pixel_y), 32'd0);
    checkEq("reset pixel_out", 32'(pixel_out), 32'd0);
    checkEq("reset fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    checkEq("reset line_request", 32'(line_request), 32'd0);
    checkEq("reset resync_req", 32'(resync_req), 32'd0);
    checkEq("reset underflow_count", 32'(underflow_count), 32'd0);
    rst = 1'b0;
    resetModel();

    // Empty FIFO for two frames: stays in WAIT, still requests lines.
    pops = 0; linePulses = 0;
    repeat (2 * FRAME) tick(1'b1);
    checkEq("starved pops", 32'(pops), 32'd0);
    checkEq("starved line pulses", 32'(linePulses), 32'(2 * VV));

    // Ramp data, never empty.
    rampMode = 1'b1; nextWord = 16'd0;
    waitMode(M_RUN, 1'b0, "enter RUN timeout");
    capAOn = 1; capAX = 0;      capAY = 0;
    capBOn = 1; capBX = HV - 1; capBY = 0;
    pops = 0;
    repeat (FRAME) tick(1'b0);
    checkEq("ramp pops per frame", 32'(pops), 32'(HV * VV));
    checkEq("ramp pixel (0,0)", 32'(capAVal), 32'd0);
    checkEq("ramp pixel (last,0)", 32'(capBVal), 32'(HV - 1));

    // Underflow mid-frame at (4,3).
    rampMode = 1'b0;
    tickUntil(4, 3, 1'b0, "reach (4,3) timeout");
    resyncPulses = 0;
    capAOn = 1; capAX = 4; capAY = 3;
    waitMode(M_WAIT, 1'b1, "fault to WAIT timeout");
    checkEq("underflow pixel (4,3)", 32'(capAVal), 32'(FILL));
    checkEq("single resync pulse", 32'(resyncPulses), 32'd1);
    checkEq("underflow count one", 32'(underflow_count), 32'd1);
    waitMode(M_RUN, 1'b0, "re-enter RUN timeout");

    // Underflow on the last visible pixel: the whole next frame stays in FAULT.
    tickUntil(HV - 1, VV - 1, 1'b0, "reach last visible timeout");
    tick(1'b1);
    tickUntil(0, 0, 1'b0, "reach frame start timeout");
    pops = 0; linePulses = 0;
    capAOn = 1; capAX = 0; capAY = 0;
    repeat (FRAME) tick(1'b0);
    checkEq("fault frame pops", 32'(pops), 32'd0);
    checkEq("fault frame line pulses", 32'(linePulses), 32'd0);
    checkEq("fault frame pixel (0,0)", 32'(capAVal), 32'(FILL));
    waitMode(M_RUN, 1'b0, "recover RUN timeout");

    // Random starvation across several frames.
    repeat (8 * FRAME) tick(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);

    // Drive enough underflows to saturate the counter.
    for (int k = 0; k < CNT_MAX + 3; k++) begin
      waitMode(M_RUN, 1'b0, "saturate RUN timeout");
      waitMode(M_FAULT, 1'b1, "saturate FAULT timeout");
    end
    checkEq("underflow count saturated", 32'(underflow_count), 32'(CNT_MAX));

    // Reset mid-frame while popping.
    waitMode(M_RUN, 1'b0, "pre-reset RUN timeout");
    tickUntil(5, 3, 1'b0, "reach (5,3) timeout");
    applyStimulus(1'b0);
    rst = 1'b1;
    #1;
    checkEq("mid reset fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    checkEq("mid reset pixel_out", 32'(pixel_out), 32'd0);
    checkEq("mid reset pixel_x", 32'(pixel_x), 32'd0);
    checkEq("mid reset pixel_y", 32'(pixel_y), 32'd0);
    checkEq("mid reset underflow_count", 32'(underflow_count), 32'd0);
    checkEq("mid reset line_request", 32'(line_request), 32'd0);
    @(posedge clk25);
    #1;
    checkEq("held reset fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;
    resetModel();
    pops = 0;
    repeat (HT * 2) tick(1'b0);
    checkEq("post reset WAIT pops", 32'(pops), 32'd0);
    waitMode(M_RUN, 1'b0, "post reset RUN timeout");
    repeat (FRAME) tick(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 Parameters SHALL be: H_TOTAL 1056, horizontal count incl. sync and porches; V_TOTAL 628, vertical count; H_VISIBLE 800, active columns; V_VISIBLE 600, active lines; UNDERFLOW_COLOUR 16'hF81F, fill colour on starvation.
REQ-002 clk25  input  1  pixel clock; one clock only, all logic on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 fifo_data  input  16  RGB565 word from the line FIFO, valid one cycle after fifo_rd_en.
REQ-005 fifo_empty  input  1  FIFO holds no words.
REQ-006 fifo_rd_en  output  1  pop one word from the FIFO this cycle.
REQ-007 pixel_out  output  16  pixel for the DAC stage, aligned with pixel_x and pixel_y.
REQ-008 pixel_x  output  11  column of pixel_out, 0..H_TOTAL-1.
REQ-009 pixel_y  output  11  line of pixel_out, 0..V_TOTAL-1.
REQ-010 line_request  output  1  one-cycle pulse asking upstream to fetch the next visible line.
REQ-011 resync_req  output  1  one-cycle pulse asking upstream to flush and restart at frame start.
REQ-012 underflow_count  output  16  starvation events; saturates at 16'hFFFF.

Function
REQ-013 Stage-0 counters cx and cy SHALL advance every cycle: cx wraps H_TOTAL-1->0; cy increments on cx wrap and wraps V_TOTAL-1->0.
REQ-014 Visible SHALL mean cx<H_VISIBLE and cy<V_VISIBLE.
REQ-015 pixel_x and pixel_y SHALL be cx and cy registered once, giving exactly 1 cycle of latency that matches the FIFO read latency.
REQ-016 FSM states SHALL be WAIT, RUN and FAULT.
REQ-017 WAIT: fifo_rd_en=0 and pixel_out=0; go to RUN only in the cycle where cx=H_TOTAL-1, cy=V_TOTAL-1 and fifo_empty=0.
REQ-018 RUN: fifo_rd_en = visible AND NOT fifo_empty; the cycle after a pop, pixel_out=fifo_data.
REQ-019 RUN, non-visible cycles: pixel_out=0 the following cycle.
REQ-020 RUN, visible cycle with fifo_empty=1 (underflow): no pop; the following cycle pixel_out=UNDERFLOW_COLOUR; underflow_count+1 (saturating); resync_req pulses; state goes to FAULT.
REQ-021 FAULT: no pops; visible pixels SHALL be UNDERFLOW_COLOUR and non-visible pixels 0; at cx=H_TOTAL-1, cy=V_TOTAL-1 the state goes to WAIT.
REQ-022 line_request SHALL pulse in RUN or WAIT when cx=H_VISIBLE and cy<V_VISIBLE-1, and when cx=H_VISIBLE and cy=V_TOTAL-1 (prefetch of line 0); it SHALL never pulse in FAULT.
REQ-023 When an underflow and a frame wrap coincide, underflow handling SHALL take precedence, and FAULT SHALL persist through the whole following frame.
REQ-024 pixel_out SHALL be 0 whenever the registered position is non-visible, regardless of state.

Reset
REQ-025 While rst is high: cx=cy=0, pixel_x=pixel_y=0, pixel_out=0, fifo_rd_en=0, line_request=0, resync_req=0, underflow_count=0, state=WAIT.
REQ-026 Assertion of rst mid-frame SHALL abort immediately with no further pops; after release, counting restarts at (0,0).

Structure
REQ-027 A shared package SHALL hold the timing constants (H_TOTAL, V_TOTAL, H_VISIBLE, V_VISIBLE), the RGB565 colour constants and the FSM state encoding.
REQ-028 The cx/cy generator SHALL be one sub-module, vga_position_counter.
REQ-029 The FSM and the output register SHALL live in pixel_feeder.

Verification
REQ-030 Reset release, fifo_empty=1 -> state WAIT, zero pops, pixel_out=0 for 2 frames; line_request pulses at cx=800.
REQ-031 FIFO preloaded with ramp data 0,1,2,... and never empty -> after WAIT->RUN, pixel (0,0)=0 and (799,0)=799; pixel_out=0 at x=800..1055; exactly 480000 pops per frame.
REQ-032 FIFO goes empty at frame position (100,5) -> pixel_out=16'hF81F from (100,5) onward; resync_req pulses once; underflow_count=1; state WAIT after frame end, RUN on the next frame once data is present.
REQ-033 Force 65536 underflows -> underflow_count holds 16'hFFFF.
REQ-034 rst pulse at (400,300) in RUN -> fifo_rd_en drops in the same cycle; outputs 0; after release, position restarts at (0,0) in WAIT.
REQ-035 Underflow at (799,599) -> FAULT covers all of the next frame before WAIT; the counters wrap cleanly at 1055 and 627.
